mdu_iter: RTL and testbench

- Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core; sits beside the ALU in the E stage.
- Multiply has a fixed latency set by parameter, with a behavioural product.
- Divide is a true iterative restoring divider, one quotient bit per cycle.
- Adds multiply-accumulate ops (madd/maddu/msub/msubu), a cancel input for exception flush, and defined divide-by-zero and overflow behaviour.

---
 rtl/mdu_pkg.sv | 47 ++++
 rtl/mdu_div_core.sv | 70 +++++++
 rtl/mdu_iter.sv | 212 +++++++++++++++++++++
 tb/tb_mdu_iter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared definitions for the iterative multiply/divide unit:
//            MD op encodings, FSM state encoding and op-class decode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam logic [3:0] MD_MULT  = 4'h0;
  localparam logic [3:0] MD_MULTU = 4'h1;
  localparam logic [3:0] MD_DIV   = 4'h2;
  localparam logic [3:0] MD_DIVU  = 4'h3;
  localparam logic [3:0] MD_MADD  = 4'h4;
  localparam logic [3:0] MD_MADDU = 4'h5;
  localparam logic [3:0] MD_MSUB  = 4'h6;
  localparam logic [3:0] MD_MSUBU = 4'h7;
  localparam logic [3:0] MD_MTHI  = 4'h8;
  localparam logic [3:0] MD_MTLO  = 4'h9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_e;

  // Ops that occupy the fixed-latency multiplier path.
  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops whose operands are interpreted as two's complement.
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) ||
           (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdu_div_core
// Purpose  : Unsigned iterative restoring divider, one quotient bit per step.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            load            - capture dividend/divisor, clear state
//            step            - perform one restoring iteration
//            dividend/divisor- unsigned operands (sampled on load)
//            quotient        - quotient register
//            remainder       - partial/final remainder
//            done            - high once WIDTH steps have completed
// Revision : 1.0 - initial release
// ============================================================================
module mdu_div_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] steps;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // The next dividend bit is shifted in from the top of the quotient
  // register, which initially holds the dividend itself.
  always_comb begin
    shifted = {remainder, quotient[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
      steps     <= '0;
      done      <= 1'b0;
    end else if (load) begin
      dvsr      <= divisor;
      quotient  <= dividend;
      remainder <= '0;
      steps     <= '0;
      done      <= 1'b0;
    end else if (step) begin
      // trial[WIDTH] is the borrow: clear means the subtraction fits.
      if (!trial[WIDTH]) begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
      steps <= steps + 1'b1;
      done  <= (steps == CNT_W'(WIDTH - 1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Purpose  : Multiply/divide unit with HI/LO for the E stage. Fixed-latency
//            behavioural multiply (with multiply-accumulate), iterative
//            restoring divide, cancel for exception flush.
// Ports    : clk, reset  - clock, synchronous active-high reset
//            start, op   - valid MD op and its encoding (mdu_pkg)
//            src_a/src_b - rs/rt operands (src_a is mthi/mtlo data)
//            cancel      - abort in-flight op, discard result
//            hi, lo      - architectural HI/LO registers
//            busy        - registered, high while an op is in flight
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  generate
    if (MUL_LAT < 1) begin : g_bad_mul_lat
      $error("mdu_iter: MUL_LAT must be at least 1");
    end
    if ((2 ** CNT_W) <= ((MUL_LAT > WIDTH + 1) ? MUL_LAT : WIDTH + 1)) begin : g_bad_cnt_w
      $error("mdu_iter: CNT_W too small for MUL_LAT/WIDTH");
    end
  endgenerate

  mdu_state_e state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             q_neg, r_neg, div_zero;

  logic accept_mul, accept_div, wr_hi, wr_lo;
  logic div_step, mul_commit, div_commit;

  logic [WIDTH-1:0] div_quo, div_rem;
  logic             div_done;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n    = state;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    div_step   = 1'b0;
    mul_commit = 1'b0;
    div_commit = 1'b0;
    case (state)
      IDLE: begin
        // Cancel in the same cycle as start suppresses every op, mthi/mtlo too.
        if (start && !cancel) begin
          if (is_mul(op)) begin
            accept_mul = 1'b1;
            state_n    = MUL;
          end else if (is_div(op)) begin
            accept_div = 1'b1;
            state_n    = DIV;
          end else if (op == MD_MTHI) begin
            wr_hi = 1'b1;
          end else if (op == MD_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      MUL: begin
        if (cancel) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          mul_commit = 1'b1;
          state_n    = IDLE;
        end
      end
      DIV: begin
        if (cancel) begin
          state_n = IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt == '0) state_n = FIX;
        end
      end
      FIX: begin
        state_n    = IDLE;
        div_commit = !cancel && !div_zero && div_done;
      end
      default: state_n = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Divide operand conditioning: the core only sees magnitudes.
  // --------------------------------------------------------------------------
  logic             div_signed;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    div_signed = (op == MD_DIV);
    abs_a      = (div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    abs_b      = (div_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  mdu_div_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_div),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // --------------------------------------------------------------------------
  // Multiply / accumulate result. All arithmetic is modulo 2^(2*WIDTH), so a
  // 2*WIDTH-bit product of extended operands is exact for both signednesses.
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] ext_a, ext_b, product, hilo, mul_result;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    ext_a   = is_signed_op(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b   = is_signed_op(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = ext_a * ext_b;
    hilo    = {hi, lo};
    case (op_q)
      MD_MADD, MD_MADDU: mul_result = hilo + product;
      MD_MSUB, MD_MSUBU: mul_result = hilo - product;
      default:           mul_result = product;
    endcase
    // Negating MIN yields MIN, which gives MIN/-1 its defined result.
    quo_fix = q_neg ? -div_quo : div_quo;
    rem_fix = r_neg ? -div_rem : div_rem;
  end

  // --------------------------------------------------------------------------
  // Datapath and HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (accept_mul) begin
        cnt  <= CNT_W'(MUL_LAT - 1);
        op_q <= op;
        a_q  <= src_a;
        b_q  <= src_b;
      end else if (accept_div) begin
        cnt      <= CNT_W'(WIDTH - 1);
        op_q     <= op;
        q_neg    <= div_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        r_neg    <= div_signed && src_a[WIDTH-1];
        div_zero <= (src_b == '0);
      end else if ((state == MUL || state == DIV) && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (wr_hi) hi <= src_a;
      if (wr_lo) lo <= src_a;

      if (mul_commit) begin
        {hi, lo} <= mul_result;
      end else if (div_commit) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Purpose  : Directed self-checking bench for mdu_iter (WIDTH=32, MUL_LAT=5).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic [31:0] hi, lo;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int n;

  mdu_iter #(
    .WIDTH   (32),
    .MUL_LAT (5),
    .CNT_W   (6)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents the op for one posedge, returns at the
  // following negedge (first busy cycle for mul/div).
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles sampled on negedges, bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy !== 1'b0 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // mult / multu
    do_op(MD_MULT, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    chk("mult_lat", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    do_op(MD_MULTU, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    chk("multu_hi", hi, 32'h00000006);
    chk("multu_lo", lo, 32'hFFFFFFEB);

    // div / divu
    do_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_lat", 32'(n), 32'd33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    do_op(MD_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // mthi / mtlo / accumulate
    do_op(MD_MTHI, 32'h1, 32'h0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    do_op(MD_MTLO, 32'hFFFFFFFF, 32'h0);
    chk("mthi_hi", hi, 32'h1);
    chk("mtlo_lo", lo, 32'hFFFFFFFF);
    do_op(MD_MADDU, 32'd1, 32'd1);
    wait_idle(n);
    chk("maddu_lat", 32'(n), 32'd5);
    chk("maddu_hi", hi, 32'h2);
    chk("maddu_lo", lo, 32'h0);
    do_op(MD_MSUB, 32'd1, 32'd1);
    wait_idle(n);
    chk("msub_hi", hi, 32'h1);
    chk("msub_lo", lo, 32'hFFFFFFFF);

    // divide by zero leaves HI/LO alone
    do_op(MD_MTHI, 32'hA, 32'h0);
    do_op(MD_MTLO, 32'hB, 32'h0);
    do_op(MD_DIV, 32'd5, 32'd0);
    wait_idle(n);
    chk("div0_lat", 32'(n), 32'd33);
    chk("div0_hi", hi, 32'hA);
    chk("div0_lo", lo, 32'hB);

    // signed overflow
    do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);

    // cancel in busy cycle 10, then immediate mult
    do_op(MD_MTHI, 32'h11, 32'h0);
    do_op(MD_MTLO, 32'h22, 32'h0);
    do_op(MD_DIV, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, 32'h11);
    chk("cancel_lo", lo, 32'h22);
    do_op(MD_MULT, 32'd2, 32'd3);
    chk("post_cancel_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("post_cancel_lat", 32'(n), 32'd5);
    chk("post_cancel_hi", hi, 32'h0);
    chk("post_cancel_lo", lo, 32'h6);

    // cancel on the FIX cycle: no commit
    do_op(MD_DIV, 32'd100, 32'd3);
    repeat (32) @(negedge clk);
    chk("fix_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("fixcancel_busy", {31'd0, busy}, 32'd0);
    chk("fixcancel_hi", hi, 32'h0);
    chk("fixcancel_lo", lo, 32'h6);

    // start while busy is ignored: exactly one accumulate
    do_op(MD_MADD, 32'd1, 32'd1);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    chk("ignore_lat", 32'(n), 32'd2);
    repeat (3) @(negedge clk);
    chk("ignore_busy", {31'd0, busy}, 32'd0);
    chk("ignore_hi", hi, 32'h0);
    chk("ignore_lo", lo, 32'h7);

    // reset mid-DIV
    do_op(MD_DIV, 32'd100, 32'd3);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstdiv_busy", {31'd0, busy}, 32'd0);
    chk("rstdiv_hi", hi, 32'h0);
    chk("rstdiv_lo", lo, 32'h0);
    repeat (40) @(negedge clk);
    chk("rstdiv_quiet", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
